// File: rtl/cpu_bus_write_capture.sv
// rtl/cpu_bus_write_capture.sv - NES CPU bus sampler that turns completed $8000-$FFFF writes into a one-clock strobe.
// Optional feature macro: BUS_CONFLICT_EN (committed data = cpu data AND flash data).
module cpu_bus_write_capture #(
  parameter int          SYNC_STAGES     = 2,
  parameter int          MIN_HIGH_CYCLES = 3,
  parameter logic [7:0]  RESET_BANK      = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  rom_data_in,
  output logic        wr_strobe,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  bank,
  output logic [7:0]  glitch_count
);

  typedef enum logic [2:0] {IDLE, COUNT, ARMED, COMMIT, IGNORE} state_t;

  localparam logic [4:0] MIN_W = 5'(MIN_HIGH_CYCLES);

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] m2_sync_q, romsel_sync_q, rw_sync_q;
  logic [14:0] addr_pipe_q [SYNC_STAGES];
  logic [7:0]  data_pipe_q [SYNC_STAGES];
  logic        m2_s, romsel_s, rw_s;
  logic [14:0] addr_al;
  logic [7:0]  data_al;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  cnt_inc;
  logic [14:0] cap_addr_q;
  logic [7:0]  cap_data_q;
  logic [14:0] wr_addr_q;
  logic [7:0]  wr_data_q, bank_q, glitch_q;
  logic        capture_en, glitch_inc, reached, write_cycle;

  assign m2_s     = m2_sync_q[SYNC_STAGES-1];
  assign romsel_s = romsel_sync_q[SYNC_STAGES-1];
  assign rw_s     = rw_sync_q[SYNC_STAGES-1];
  assign addr_al  = addr_pipe_q[SYNC_STAGES-1];

`ifdef BUS_CONFLICT_EN
  logic [7:0] rom_pipe_q [SYNC_STAGES];
  // Unprotected boards: the flash drives the bus too, so the bits AND together.
  assign data_al = data_pipe_q[SYNC_STAGES-1] & rom_pipe_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rom_pipe_q[i] <= '0;
    end else begin
      rom_pipe_q[0] <= rom_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) rom_pipe_q[i] <= rom_pipe_q[i-1];
    end
  end
`else
  logic rom_data_unused;
  assign rom_data_unused = ^rom_data_in;
  assign data_al = data_pipe_q[SYNC_STAGES-1];
`endif

  // Address/data pipelines match the control synchronizer depth to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync_q     <= '0;
      romsel_sync_q <= '0;
      rw_sync_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_pipe_q[i] <= '0;
        data_pipe_q[i] <= '0;
      end
    end else begin
      m2_sync_q      <= {m2_sync_q[SYNC_STAGES-2:0], m2};
      romsel_sync_q  <= {romsel_sync_q[SYNC_STAGES-2:0], romsel};
      rw_sync_q      <= {rw_sync_q[SYNC_STAGES-2:0], cpu_rw_in};
      addr_pipe_q[0] <= cpu_addr_in;
      data_pipe_q[0] <= cpu_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_pipe_q[i] <= addr_pipe_q[i-1];
        data_pipe_q[i] <= data_pipe_q[i-1];
      end
    end
  end

  assign cnt_inc     = {1'b0, cnt_q} + 5'd1;
  assign reached     = (cnt_inc >= MIN_W);
  assign write_cycle = !romsel_s && !rw_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m2_s) state_d = COUNT;
      COUNT: begin
        if (!m2_s)        state_d = IDLE;
        else if (reached) state_d = write_cycle ? ARMED : IGNORE;
      end
      ARMED: begin
        if (rw_s || (romsel_s && m2_s)) state_d = IGNORE;
        else if (!m2_s)                 state_d = COMMIT;
      end
      COMMIT:  state_d = m2_s ? COUNT : IDLE;
      IGNORE:  if (!m2_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_strobe  = (state_q == COMMIT);
    capture_en = 1'b0;
    glitch_inc = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE:   cnt_d = m2_s ? 4'd1 : 4'd0;
      COUNT: begin
        if (!m2_s) begin
          glitch_inc = ({1'b0, cnt_q} < MIN_W);
        end else begin
          cnt_d      = (cnt_q == 4'hF) ? cnt_q : cnt_inc[3:0];
          capture_en = reached && write_cycle;
        end
      end
      ARMED:  capture_en = m2_s && write_cycle;
      COMMIT: cnt_d = m2_s ? 4'd1 : 4'd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      bank_q     <= RESET_BANK;
      glitch_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (capture_en) begin
        cap_addr_q <= addr_al;
        cap_data_q <= data_al;
      end
      if (state_q == COMMIT) begin
        wr_addr_q <= cap_addr_q;
        wr_data_q <= cap_data_q;
        bank_q    <= cap_data_q;
      end
      if (glitch_inc && glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
    end
  end

  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign bank         = bank_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_cpu_bus_write_capture.sv
// tb/tb_cpu_bus_write_capture.sv - directed self-checking bench for cpu_bus_write_capture.
module tb_cpu_bus_write_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m2, romsel, cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in, rom_data_in;
  logic        wr_strobe;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data, bank, glitch_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = -100;
  int fall_cyc = 0;
  int base;

  cpu_bus_write_capture dut (
    .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .rom_data_in(rom_data_in),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .bank(bank),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU bus cycle; m2 is high for exactly high_clks rising edges.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input int high_clks);
    @(negedge clk);
    cpu_addr_in = a[14:0];
    cpu_data_in = d;
    cpu_rw_in   = rw;
    @(negedge clk);
    m2     = 1'b1;
    romsel = ~a[15];
    repeat (high_clks) @(negedge clk);
    m2       = 1'b0;
    romsel   = 1'b1;
    fall_cyc = cyc;
    repeat (8) @(negedge clk);
    cpu_rw_in = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; m2 = 1'b0; romsel = 1'b1; cpu_rw_in = 1'b1;
    cpu_addr_in = '0; cpu_data_in = '0; rom_data_in = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("reset_bank", bank, 8'h00);
    check_eq("reset_glitch", glitch_count, 8'h00);
    check_eq("reset_wr_addr", wr_addr, 15'h0000);
    check_eq("idle_no_strobe", strobe_cnt, 0);

    bus_cycle(16'h8000, 8'h15, 1'b0, 12);
    check_eq("w8000_strobes", strobe_cnt, 1);
    check_eq("w8000_addr", wr_addr, 15'h0000);
    check_eq("w8000_data", wr_data, 8'h15);
    check_eq("w8000_bank", bank, 8'h15);
    check_eq("w8000_latency", strobe_cyc - fall_cyc, 3);
    check_eq("w8000_glitch", glitch_count, 8'h00);

    bus_cycle(16'hC000, 8'h3C, 1'b1, 12);
    bus_cycle(16'h6000, 8'h2A, 1'b0, 12);
    check_eq("read_wram_strobes", strobe_cnt, 1);
    check_eq("read_wram_bank", bank, 8'h15);

    rom_data_in = 8'hFF;
    bus_cycle(16'hFFFF, 8'hA5, 1'b0, 3);
    check_eq("min_high_strobes", strobe_cnt, 2);
    check_eq("min_high_addr", wr_addr, 15'h7FFF);
    check_eq("min_high_bank", bank, 8'hA5);

    bus_cycle(16'h8000, 8'h42, 1'b0, 2);
    check_eq("glitch_one", glitch_count, 8'h01);
    check_eq("glitch_no_strobe", strobe_cnt, 2);
    check_eq("glitch_bank", bank, 8'hA5);
    for (int i = 0; i < 299; i++) bus_cycle(16'h8000, 8'h42, 1'b0, 2);
    check_eq("glitch_saturate", glitch_count, 8'hFF);
    check_eq("glitch_many_no_strobe", strobe_cnt, 2);

    rom_data_in = 8'h13;
    bus_cycle(16'h8000, 8'h1F, 1'b0, 10);
    check_eq("conflict_strobes", strobe_cnt, 3);
`ifdef BUS_CONFLICT_EN
    check_eq("conflict_data", wr_data, 8'h13);
`else
    check_eq("conflict_data", wr_data, 8'h1F);
`endif
    rom_data_in = 8'hFF;

    // Reset while ARMED, released one clock before m2 falls.
    base = strobe_cnt;
    @(negedge clk);
    cpu_addr_in = 15'h0000; cpu_data_in = 8'h07; cpu_rw_in = 1'b0;
    @(negedge clk);
    m2 = 1'b1; romsel = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m2 = 1'b0; romsel = 1'b1;
    repeat (10) @(negedge clk);
    cpu_rw_in = 1'b1;
    check_eq("reset_armed_no_strobe", strobe_cnt - base, 0);
    check_eq("reset_armed_bank", bank, 8'h00);
    check_eq("reset_armed_wr_data", wr_data, 8'h00);

    bus_cycle(16'hA000, 8'h5A, 1'b0, 6);
    check_eq("post_reset_strobes", strobe_cnt - base, 1);
    check_eq("post_reset_addr", wr_addr, 15'h2000);
    check_eq("post_reset_bank", bank, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
